efx_cdc_hs_tx: RTL and testbench
================================

Name: efx_cdc_hs_tx

Overview:
- Source-side half of a two-phase (toggle) request/acknowledge CDC handshake; runs entirely in the sending clock domain.
- Captures a data word from a local valid/ready interface, holds it stable on `xfer_data_o` and toggles `xfer_req_o` toward the destination domain.
- Waits for the destination's acknowledge toggle, re-synchronized internally through a STAGE-deep flop chain, before accepting the next word.
- Pairs with the team's existing multi-flop synchronizer used on the receive side.

Parameters:
- STAGE, 2, depth of the internal ack synchronizer chain (legal values ≥ 2).
- WIDTH, 32, data word width in bits.
- TIMEOUT, 1023, wait-cycle limit used only when EFX_HS_TIMEOUT_EN is defined (legal values ≥ 1).

Ports:
- clk_i  input  1  source-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- src_data_i  input  WIDTH  word to transfer.
- src_valid_i  input  1  src_data_i valid.
- src_ready_o  output  1  block can accept a word this cycle.
- done_o  output  1  one-cycle pulse: previous transfer acknowledged.
- xfer_data_o  output  WIDTH  registered data bus to destination; stable while a request is pending.
- xfer_req_o  output  1  request toggle to destination.
- xfer_ack_i  input  1  acknowledge toggle from destination; asynchronous to clk_i.
- err_o  output  1  sticky protocol error.
- timeout_o  output  1  sticky timeout flag; constant 0 without the macro.

Behaviour:
- Clocking and reset: one clock (clk_i). Reset is asynchronous and active-low on rst_n; all flops are cleared on assertion.
- Reset values:
  - state IDLE
  - xfer_req_o = 0, xfer_data_o = 0
  - ack sync chain all 0
  - done_o = 0, err_o = 0, timeout_o = 0
  - src_ready_o = 1 immediately after reset (IDLE with ack_sync == req).
- ack_sync: last flop of a STAGE-deep chain on xfer_ack_i. Mark the chain flops as async registers. Data in the chain is never reset-gated beyond rst_n.
- src_ready_o is combinational: (state == IDLE) && (ack_sync == xfer_req_o) && !err_o.
- IDLE state:
  - src_valid_i && src_ready_o at edge n: xfer_data_o <= src_data_i, xfer_req_o <= ~xfer_req_o, state <= WAIT.
  - The new values are visible after edge n; src_ready_o is 0 from edge n onward.
  - src_data_i is sampled only on the accepting edge.
- WAIT state:
  - xfer_data_o and xfer_req_o are held constant.
  - When ack_sync == xfer_req_o at edge m: state <= IDLE, done_o = 1 for exactly the cycle after edge m, src_ready_o = 1 in that same cycle.
- Back-to-back transfers: a word may be accepted in the same cycle done_o is high. Minimum cycles per transfer is 2 plus the destination round trip plus STAGE.
- Protocol error:
  - In IDLE, if ack_sync != xfer_req_o (e.g. destination reset alone, or a spurious ack toggle), set err_o. It stays set until rst_n.
  - While err_o is set, src_ready_o = 0; the block stalls and never issues a request.
  - An ack toggle arriving in WAIT is the normal completion path and never an error.
- Reset mid-transfer: any pending request is abandoned, outputs return to reset values, and done_o is not emitted. Both domains must be reset together; otherwise err_o flags the mismatch.
- src_valid_i deasserted while src_ready_o = 1 has no effect. src_valid_i high while src_ready_o = 0 has no effect, and the word is not captured.

Optional Feature:
- Macro: EFX_HS_TIMEOUT_EN.
- When defined:
  - A wait counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each cycle in WAIT, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT, timeout_o is set (sticky until rst_n).
  - The FSM stays in WAIT and does not abort; a later ack still completes normally and still emits done_o.
- When not defined: no counter exists and timeout_o is tied to 0.

Test Plan:
- Reset release with STAGE=2 and xfer_ack_i=0 → src_ready_o=1, xfer_req_o=0, xfer_data_o=0, err_o=0.
- src_data_i=32'hDEADBEEF with valid for 1 cycle; bench toggles xfer_ack_i 5 cycles after xfer_req_o rises → xfer_data_o=DEADBEEF held throughout; done_o pulses 1 cycle, exactly STAGE+1 edges after the ack toggle; src_ready_o returns to 1 in the same cycle.
- Four back-to-back words 1,2,3,4 with valid held high and the bench echoing req to ack → xfer_req_o toggles 4 times; words delivered in order; 4 done_o pulses; no word is captured while src_ready_o=0.
- Toggle xfer_ack_i while IDLE → err_o=1 after STAGE edges; src_ready_o stays 0 despite src_valid_i=1; rst_n pulse clears both.
- Assert rst_n low during WAIT → xfer_req_o=0 and done_o never pulses; after release, a normal transfer completes.
- With EFX_HS_TIMEOUT_EN and TIMEOUT=8, withhold ack → timeout_o=1 after 8 WAIT cycles; a later ack still yields done_o; timeout_o stays 1.

Source files
------------

// File: rtl/efx_cdc_hs_tx.sv
// efx_cdc_hs_tx: source half of a two-phase req/ack CDC handshake. It holds one word in flight on xfer_data_o.
// Latency: req toggles 1 edge after accept. done_o pulses STAGE+1 edges after the ack toggle lands.
// Backpressure: src_ready_o is low while a request is pending or after a protocol error. EFX_HS_TIMEOUT_EN adds a wait timeout.
module efx_cdc_hs_tx #(
    parameter int STAGE   = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src_data_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] xfer_data_o,
    output logic             xfer_req_o,
    input  logic             xfer_ack_i,
    output logic             err_o,
    output logic             timeout_o
);

    if (STAGE < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("efx_cdc_hs_tx: STAGE must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           state_q;
    logic             req_q;
    logic [WIDTH-1:0] data_q;
    logic             done_q;
    logic             err_q;
    logic             ack_sync;
    logic             ack_next;
    logic             accept;

    (* ASYNC_REG = "TRUE" *) logic [STAGE-1:0] ack_meta_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= '0;
        end else begin
            ack_meta_q <= {ack_meta_q[STAGE-2:0], xfer_ack_i};
        end
    end

    assign ack_sync    = ack_meta_q[STAGE-1];
    assign ack_next    = ack_meta_q[STAGE-2];
    assign src_ready_o = (state_q == S_IDLE) && (ack_sync == req_q) && !err_q;
    assign accept      = src_valid_i && src_ready_o;

    // An ack toggle that arrives while idle is flagged on the edge where it reaches ack_sync.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if ((ack_sync != req_q) || (ack_next != req_q)) begin
                        err_q <= 1'b1;
                    end
                    if (accept) begin
                        data_q  <= src_data_i;
                        req_q   <= ~req_q;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ack_sync == req_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign xfer_data_o = data_q;
    assign xfer_req_o  = req_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef EFX_HS_TIMEOUT_EN
    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    // The counter sits at zero while idle, so entering WAIT always starts the count from zero.
    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((state_q == S_WAIT) && (cnt_d == TO_MAX)) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_efx_cdc_hs_tx.sv
// Directed plus randomized bench for efx_cdc_hs_tx, with a destination-side echo model.
module tb_efx_cdc_hs_tx;
    localparam int STAGE   = 2;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;
    localparam int BUDGET  = 3000;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] src_data_i = '0;
    logic             src_valid_i = 1'b0;
    logic             src_ready_o;
    logic             done_o;
    logic [WIDTH-1:0] xfer_data_o;
    logic             xfer_req_o;
    logic             xfer_ack_i;
    logic             err_o;
    logic             timeout_o;

    logic ack_dst = 1'b0;
    logic ack_man = 1'b0;
    assign xfer_ack_i = ack_dst ^ ack_man;

    int  total = 0;
    int  bad = 0;
    bit  echo_en = 1'b0;
    int  done_cnt = 0;
    int  tgl_cnt = 0;
    logic prev_req = 1'b0;
    logic prev_done = 1'b0;
    logic [WIDTH-1:0] rcvd[$];
    logic [WIDTH-1:0] echo_w;
    int  n;
    int  d0;
    bit  held_ok;
    logic             r_req;
    logic [WIDTH-1:0] r_data;

    efx_cdc_hs_tx #(.STAGE(STAGE), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .src_data_i  (src_data_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .done_o      (done_o),
        .xfer_data_o (xfer_data_o),
        .xfer_req_o  (xfer_req_o),
        .xfer_ack_i  (xfer_ack_i),
        .err_o       (err_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: counts req toggles and done pulses, checks done is one cycle and coincides with ready.
    always @(negedge clk_i) begin
        if (!rst_n) begin
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (xfer_req_o !== prev_req) tgl_cnt++;
            if (done_o === 1'b1) begin
                done_cnt++;
                chk("done_ready", src_ready_o, 1);
                chk("done_width", prev_done, 0);
            end
            prev_req  = xfer_req_o;
            prev_done = done_o;
        end
    end

    // Destination model: latch the word on a req toggle, wait 0-3 cycles, echo req back as ack.
    always begin
        @(negedge clk_i);
        if (!rst_n) begin
            ack_dst = 1'b0;
        end else if (echo_en && (xfer_req_o !== xfer_ack_i)) begin
            echo_w = xfer_data_o;
            rcvd.push_back(echo_w);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            chk("data_held", xfer_data_o, echo_w);
            if (rst_n) ack_dst = ~ack_dst;
        end
    end

    task automatic run_burst(input int cnt, input bit rnd);
        logic [WIDTH-1:0] w[$];
        int idx = 0;
        int cyc = 0;
        for (int i = 0; i < cnt; i++) w.push_back(rnd ? WIDTH'($urandom) : WIDTH'(i + 1));
        rcvd.delete();
        done_cnt = 0;
        tgl_cnt  = 0;
        echo_en  = 1'b1;
        while (idx < cnt && cyc < BUDGET) begin
            src_valid_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            src_data_i  = src_valid_i ? w[idx] : WIDTH'($urandom);
            if (src_valid_i && src_ready_o) idx++;
            @(negedge clk_i);
            cyc++;
        end
        src_valid_i = 1'b0;
        while ((done_cnt < cnt || rcvd.size() < cnt) && cyc < BUDGET) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("burst_in_budget", cyc < BUDGET, 1);
        chk("burst_req_toggles", tgl_cnt, cnt);
        chk("burst_done_pulses", done_cnt, cnt);
        chk("burst_rcvd_count", rcvd.size(), cnt);
        for (int i = 0; i < cnt && i < rcvd.size(); i++) chk("burst_word", rcvd[i], w[i]);
        echo_en = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", src_ready_o, 1);
        chk("rst_req", xfer_req_o, 0);
        chk("rst_data", xfer_data_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_timeout", timeout_o, 0);

        // Single transfer, ack toggled 5 cycles after req
        src_data_i  = 32'hDEADBEEF;
        src_valid_i = 1'b1;
        @(negedge clk_i);
        src_valid_i = 1'b0;
        src_data_i  = WIDTH'($urandom);
        chk("t1_req", xfer_req_o, 1);
        chk("t1_data", xfer_data_o, 32'hDEADBEEF);
        chk("t1_busy", src_ready_o, 0);
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (xfer_data_o !== 32'hDEADBEEF || src_ready_o !== 1'b0 || done_o !== 1'b0) held_ok = 1'b0;
        end
        ack_man = 1'b1;
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
            if (xfer_data_o !== 32'hDEADBEEF) held_ok = 1'b0;
        end
        chk("t1_done_latency", n, STAGE + 1);
        chk("t1_ready_with_done", src_ready_o, 1);
        chk("t1_data_held", held_ok, 1);
        @(negedge clk_i);
        chk("t1_done_one_cycle", done_o, 0);

        // Back-to-back words 1..4 with valid held high
        run_burst(4, 1'b0);

        // Spurious ack toggle while idle
        @(negedge clk_i);
        chk("err_pre_ready", src_ready_o, 1);
        ack_man = ~ack_man;
        n = 0;
        while (err_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("err_latency", n, STAGE);
        chk("err_ready", src_ready_o, 0);
        r_req  = xfer_req_o;
        r_data = xfer_data_o;
        src_valid_i = 1'b1;
        src_data_i  = 32'h12345678;
        repeat (6) @(negedge clk_i);
        chk("err_stall_req", xfer_req_o, r_req);
        chk("err_stall_data", xfer_data_o, r_data);
        chk("err_stall_ready", src_ready_o, 0);
        chk("err_sticky", err_o, 1);
        src_valid_i = 1'b0;
        rst_n   = 1'b0;
        ack_man = 1'b0;
        #1;
        chk("err_rst_clear", err_o, 0);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("err_rst_ready", src_ready_o, 1);
        chk("err_rst_err", err_o, 0);

        // Reset during WAIT
        src_valid_i = 1'b1;
        src_data_i  = WIDTH'($urandom);
        @(negedge clk_i);
        src_valid_i = 1'b0;
        chk("rw_req_up", xfer_req_o, 1);
        repeat (2) @(negedge clk_i);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rw_req_cleared", xfer_req_o, 0);
        chk("rw_data_cleared", xfer_data_o, 0);
        chk("rw_done_low", done_o, 0);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("rw_no_done", done_cnt, d0);
        chk("rw_ready", src_ready_o, 1);
        run_burst(3, 1'b1);

        // Randomized traffic with gaps
        run_burst(16, 1'b1);

`ifdef EFX_HS_TIMEOUT_EN
        // Withheld ack: timeout after TIMEOUT wait cycles, later ack still completes
        src_valid_i = 1'b1;
        src_data_i  = WIDTH'($urandom);
        @(negedge clk_i);
        src_valid_i = 1'b0;
        d0 = done_cnt;
        n = 0;
        while (timeout_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("to_latency", n, TIMEOUT);
        chk("to_no_done_yet", done_cnt, d0);
        ack_man = ~ack_man;
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("to_late_done", done_o, 1);
        chk("to_sticky", timeout_o, 1);
        repeat (3) @(negedge clk_i);
        chk("to_sticky_idle", timeout_o, 1);
`else
        chk("to_tied_low", timeout_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "global timeout");
    end

endmodule
